rv64g_issue_window: RTL

RV64G_ISSUE_WINDOW -- requirements
Module: rv64g_issue_window

---
 rtl/rv64g_pkg.sv | 14 +
 rtl/rv64g_issue_ckr.sv | 33 +++
 rtl/rv64g_issue_window.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rv64g_pkg.sv
// Shared types and sizing constants for the RV64G issue window slice.
package rv64g_pkg;

  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned ISSUE_DEPTH = 4;

  typedef struct packed {
    logic [15:0]          tag;
    logic [6:0]           opcode;
    logic [NUM_REGS-1:0]  reg_req;
    logic                 jump;
  } decoded_instr_t;

endpackage

// File: rtl/rv64g_issue_ckr.sv
// Per-slot eligibility check; chained oldest-to-youngest so each slot sees
// the accumulated register requests and jump presence of all older slots.
module rv64g_issue_ckr
  import rv64g_pkg::*;
#(
  parameter int unsigned NR = NUM_REGS
) (
  input  logic          valid_i,
  input  logic [NR-1:0] req_i,
  input  logic          jump_i,
  input  logic [NR-1:0] locks_i,
  input  logic [NR-1:0] older_req_i,
  input  logic          older_any_i,
  input  logic          older_jump_i,
  output logic          eligible_o,
  output logic [NR-1:0] older_req_o,
  output logic          older_any_o,
  output logic          older_jump_o
);

  // Eligibility plus propagation of the older-slot summary to the next slot.
  always_comb begin
    eligible_o   = valid_i
                 && ((req_i & locks_i) == '0)
                 && ((req_i & older_req_i) == '0)
                 && !older_jump_i
                 && !(jump_i && older_any_i);
    older_req_o  = older_req_i | (valid_i ? req_i : '0);
    older_any_o  = older_any_i | valid_i;
    older_jump_o = older_jump_i | (valid_i & jump_i);
  end

endmodule

// File: rtl/rv64g_issue_window.sv
// Age-ordered issue window: oldest-first grant, compaction on issue and a
// single output register with valid/ready handshake.
module rv64g_issue_window
  import rv64g_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH,
  parameter int unsigned NR    = NUM_REGS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  decoded_instr_t             instr_in_i,
  input  logic                       instr_in_valid_i,
  output logic                       instr_in_ready_o,
  input  logic [NR-1:0]              locks_i,
  output decoded_instr_t             instr_out_o,
  output logic                       instr_out_valid_o,
  input  logic                       instr_out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned IW = $clog2(DEPTH);

  decoded_instr_t slot_q [DEPTH];
  decoded_instr_t slot_d [DEPTH];
  logic [CW-1:0]  count_q, count_d, count_mid;
  decoded_instr_t out_q, out_d;
  logic           out_vld_q, out_vld_d;

  logic [DEPTH-1:0] vld, elig;
  logic [NR-1:0]    chain_req [DEPTH+1];
  logic             chain_any [DEPTH+1];
  logic             chain_jmp [DEPTH+1];

  logic          grant_any, issue, accept, in_ready;
  logic [IW-1:0] gidx;

  assign chain_req[0] = '0;
  assign chain_any[0] = 1'b0;
  assign chain_jmp[0] = 1'b0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ckr
    assign vld[k] = (CW'(k) < count_q);
    rv64g_issue_ckr #(.NR(NR)) u_ckr (
      .valid_i      (vld[k]),
      .req_i        (NR'(slot_q[k].reg_req)),
      .jump_i       (slot_q[k].jump),
      .locks_i      (locks_i),
      .older_req_i  (chain_req[k]),
      .older_any_i  (chain_any[k]),
      .older_jump_i (chain_jmp[k]),
      .eligible_o   (elig[k]),
      .older_req_o  (chain_req[k+1]),
      .older_any_o  (chain_any[k+1]),
      .older_jump_o (chain_jmp[k+1])
    );
  end

  // Fixed-priority grant: scanning from the youngest down leaves the oldest hit.
  always_comb begin
    grant_any = 1'b0;
    gidx      = '0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (elig[k-1]) begin
        grant_any = 1'b1;
        gidx      = IW'(k-1);
      end
    end
  end

  assign issue    = grant_any && (!out_vld_q || instr_out_ready_i) && !clear_i && !rst_i;
  assign in_ready = !rst_i && !clear_i && ((count_q < CW'(DEPTH)) || issue);
  assign accept   = instr_in_valid_i && in_ready;

  // Next window/output state: close the gap left by the grant, then append.
  always_comb begin
    count_mid = count_q - CW'(issue);
    for (int unsigned k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
    // Shifting first means the append index is simply the post-issue count.
    for (int unsigned k = 0; k < DEPTH-1; k++) begin
      if (issue && (IW'(k) >= gidx)) slot_d[k] = slot_q[k+1];
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (accept && (CW'(k) == count_mid)) slot_d[k] = instr_in_i;
    end
    count_d   = count_mid + CW'(accept);
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (issue) begin
      out_d     = slot_q[gidx];
      out_vld_d = 1'b1;
    end else if (instr_out_ready_i) begin
      out_vld_d = 1'b0;
    end
    if (clear_i) begin
      count_d   = '0;
      out_vld_d = 1'b0;
    end
  end

  // Control and output register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  // Slot payload storage; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
  end

  assign instr_in_ready_o  = in_ready;
  assign instr_out_o       = out_q;
  assign instr_out_valid_o = out_vld_q;
  assign count_o           = count_q;

endmodule
